mem_ws: RTL and testbench

//  Parametrised single-port synchronous RAM for the minimal EDSAC datapath,

---
 rtl/mem_ws.sv | 92 +++++++++
 tb/tb_mem_ws.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ws.sv
// Single-port synchronous store with programmable wait states, optional page-mode
// bursts and a post-reset clear sweep. The rd/wr/stall handshake lets a CPU sequencer
// run unchanged against fast or slow store models.
module mem_ws #(
  parameter int              ABITS       = 9,
  parameter int              DBITS       = 16,
  parameter int              WAIT_CYCLES = 0,
  parameter int              BURST       = 0,
  parameter int              CLEAR_EN    = 1,
  parameter logic [DBITS-1:0] CLEAR_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ABITS-1:0] addr,
  input  logic [DBITS-1:0] d,
  input  logic             rd,
  input  logic             wr,
  output logic [DBITS-1:0] q,
  output logic             stall
);
  localparam int       DEPTH   = 1 << ABITS;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;
  localparam logic [3:0] WC      = 4'(WAIT_CYCLES);

  logic [DBITS-1:0] mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [ABITS-1:0] clr_addr_q, clr_addr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [DBITS-1:0] q_q, q_d;

  logic             req;
  logic             mem_we;
  logic [ABITS-1:0] mem_waddr;
  logic [DBITS-1:0] mem_wdata;

  assign req = rd | wr;
  assign q   = q_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    stall      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = d;
    if (state_q == S_CLEAR) begin
      // Sweep one word per edge; requests are ignored and the wait counter frozen.
      stall      = 1'b1;
      mem_we     = 1'b1;
      mem_waddr  = clr_addr_q;
      mem_wdata  = CLEAR_VAL;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == ABITS'(DEPTH - 1)) state_d = S_IDLE;
    end else begin
      stall = req & (cnt_q != WC);
      if (!req) begin
        cnt_d = '0;
      end else if (stall) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        // Accepting edge: in burst mode the counter stays saturated while req is held.
        cnt_d  = (BURST != 0) ? cnt_q : 4'd0;
        mem_we = wr;
        if (rd) q_d = mem[addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
      clr_addr_q <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
    end
  end

  // Storage has no reset: contents survive rst_n unless the clear sweep rewrites them.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_mem_ws.sv
// Randomised bench for mem_ws: three instances (slow non-burst, slow burst, fast
// no-clear) driven against a transaction-level store model.
module tb_mem_ws;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n_v = 3'b000;
  logic [2:0]       rd_v    = 3'b000;
  logic [2:0]       wr_v    = 3'b000;
  logic [2:0][8:0]  addr_v  = '0;
  logic [2:0][15:0] d_v     = '0;
  logic [15:0]      q0, q1, q2;
  logic             st0, st1, st2;

  mem_ws #(.ABITS(4), .DBITS(16), .WAIT_CYCLES(2), .BURST(0), .CLEAR_EN(1), .CLEAR_VAL(16'h0)) u0 (
    .clk(clk), .rst_n(rst_n_v[0]), .addr(addr_v[0][3:0]), .d(d_v[0]),
    .rd(rd_v[0]), .wr(wr_v[0]), .q(q0), .stall(st0));
  mem_ws #(.ABITS(4), .DBITS(16), .WAIT_CYCLES(3), .BURST(1), .CLEAR_EN(1), .CLEAR_VAL(16'h0)) u1 (
    .clk(clk), .rst_n(rst_n_v[1]), .addr(addr_v[1][3:0]), .d(d_v[1]),
    .rd(rd_v[1]), .wr(wr_v[1]), .q(q1), .stall(st1));
  mem_ws #(.ABITS(9), .DBITS(16), .WAIT_CYCLES(0), .BURST(0), .CLEAR_EN(0), .CLEAR_VAL(16'h0)) u2 (
    .clk(clk), .rst_n(rst_n_v[2]), .addr(addr_v[2]), .d(d_v[2]),
    .rd(rd_v[2]), .wr(wr_v[2]), .q(q2), .stall(st2));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: word store, last read value, and whether the request is still held
  logic [15:0] mdl [3][512];
  bit          kn  [3][512];
  logic [15:0] mq  [3];
  bit          mqk [3];
  bit          hold[3];

  function automatic int wc(int i);    return (i == 0) ? 2 : (i == 1) ? 3 : 0; endfunction
  function automatic bit brst(int i);  return i == 1; endfunction
  function automatic bit clr(int i);   return i != 2; endfunction
  function automatic int dep(int i);   return (i == 2) ? 512 : 16; endfunction
  function automatic logic [15:0] qof(int i);
    return (i == 0) ? q0 : (i == 1) ? q1 : q2;
  endfunction
  function automatic logic stof(int i);
    return (i == 0) ? st0 : (i == 1) ? st1 : st2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Count stall cycles after reset; requests are dropped after the reset edge.
  task automatic do_reset(input int i);
    int n;
    n = 0;
    rst_n_v[i] = 1'b0;
    @(posedge clk); #1;
    rst_n_v[i] = 1'b1;
    rd_v[i] = 1'b0; wr_v[i] = 1'b0;
    mq[i] = '0; mqk[i] = 1'b1; hold[i] = 1'b0;
    if (clr(i)) for (int a = 0; a < dep(i); a++) begin mdl[i][a] = '0; kn[i][a] = 1'b1; end
    chk($sformatf("rst_q%0d", i), qof(i), 0);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!stof(i)) break;
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk($sformatf("clr_len%0d", i), n, clr(i) ? dep(i) : 0);
  endtask

  // One request held until accepted; addr/d are scrambled while stalled and
  // restored just before the accepting edge.
  task automatic access(input int i, input bit r, input bit w, input int a0, input logic [15:0] dd);
    int a, n, exp_n;
    a = a0 % dep(i);
    rd_v[i] = r; wr_v[i] = w; addr_v[i] = 9'(a); d_v[i] = dd;
    exp_n = (brst(i) && hold[i]) ? 0 : wc(i);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stof(i)) break;
      n++;
      @(posedge clk); #1;
      addr_v[i] = 9'($urandom); d_v[i] = 16'($urandom);
    end
    addr_v[i] = 9'(a); d_v[i] = dd;
    chk($sformatf("stalls%0d", i), n, exp_n);
    @(posedge clk);
    if (r) begin mq[i] = mdl[i][a]; mqk[i] = kn[i][a]; end
    if (w) begin mdl[i][a] = dd; kn[i][a] = 1'b1; end
    #1;
    if (r && mqk[i]) chk($sformatf("q%0d_a%0d", i, a), qof(i), mq[i]);
    hold[i] = 1'b1;
  endtask

  task automatic idle(input int i, input int n);
    rd_v[i] = 1'b0; wr_v[i] = 1'b0; hold[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("idle_stall%0d", i), stof(i), 0);
      if (mqk[i]) chk($sformatf("q_hold%0d", i), qof(i), mq[i]);
      @(posedge clk); #1;
    end
  endtask

  // Request held for k stalled edges then dropped: must leave store and q untouched.
  task automatic abort(input int i, input bit r, input bit w, input int a, input logic [15:0] dd, input int k);
    if (hold[i]) idle(i, 1);
    rd_v[i] = r; wr_v[i] = w; addr_v[i] = 9'(a % dep(i)); d_v[i] = dd;
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      chk($sformatf("abt_stall%0d", i), stof(i), 1);
      @(posedge clk); #1;
    end
    idle(i, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, op;
    logic [15:0] v;
    for (int i = 0; i < 3; i++) begin
      mqk[i] = 1'b0; hold[i] = 1'b0; mq[i] = '0;
      for (int j = 0; j < 512; j++) begin kn[i][j] = 1'b0; mdl[i][j] = '0; end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) do_reset(i);

    // Cleared store reads back zero everywhere
    for (int j = 0; j < 16; j++) begin access(0, 1, 0, j, 16'h0); idle(0, 1); end

    // Wait states and read-before-write
    access(0, 0, 1, 5, 16'h1234); idle(0, 1);
    access(0, 1, 0, 5, 16'h0);    idle(0, 2);
    access(0, 0, 1, 7, 16'hAAAA); idle(0, 1);
    access(0, 1, 1, 7, 16'h5555); idle(0, 1);
    access(0, 1, 0, 7, 16'h0);    idle(0, 1);

    // Burst: first access waits, held follow-ons are immediate, dropping req rearms the wait
    access(1, 1, 0, 0, 16'h0);
    access(1, 1, 0, 1, 16'h0);
    access(1, 1, 0, 2, 16'h0);
    idle(1, 1);
    access(1, 1, 0, 3, 16'h0); idle(1, 1);

    // Abort leaves store alone
    access(1, 0, 1, 9, 16'h0F0F); idle(1, 1);
    abort(1, 0, 1, 9, 16'hDEAD, 2);
    access(1, 1, 0, 9, 16'h0); idle(1, 1);

    // Reset with a write pending mid-stall: write dropped, clear restarts
    rd_v[1] = 1'b0; wr_v[1] = 1'b1; addr_v[1] = 9'd3; d_v[1] = 16'hBEEF;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); chk("pend_stall", st1, 1); @(posedge clk); #1;
    end
    do_reset(1);
    access(1, 1, 0, 3, 16'h0); idle(1, 1);

    // Zero-wait back-to-back at both ends of the range
    access(2, 0, 1, 511, 16'hC0DE);
    access(2, 0, 1, 0,   16'h7E57);
    access(2, 1, 0, 511, 16'h0);
    access(2, 1, 0, 0,   16'h0);
    idle(2, 1);
    // Contents survive reset when no clear sweep is configured
    do_reset(2);
    access(2, 1, 0, 511, 16'h0); idle(2, 1);

    // Randomised traffic
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 60; n++) begin
        op = $urandom_range(0, 9);
        a  = (i == 2 && $urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 511 : 0)
                                                   : $urandom_range(0, dep(i) - 1);
        v  = 16'($urandom);
        if (op < 9 && $urandom_range(0, 1) == 0 && hold[i]) idle(i, 1);
        if (op <= 3)       access(i, 0, 1, a, v);
        else if (op <= 6)  access(i, 1, 0, a, v);
        else if (op == 7)  access(i, 1, 1, a, v);
        else if (op == 8) begin
          if (wc(i) > 0) begin
            abort(i, $urandom_range(0, 1) != 0, 1'b1, a, v, $urandom_range(1, wc(i)));
            access(i, 1, 0, a, 16'h0);
          end else access(i, 1, 0, a, v);
        end else idle(i, $urandom_range(1, 3));
      end
      idle(i, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
